// File: rtl/serial_subtractor8b.sv
// Bit-serial 8-bit subtractor: latches A, B, BIN on START and produces A - B - BIN one bit per cycle, LSB first.
// Optional Z/N/V flag generation is enabled by defining SERIAL_SUB_FLAGS_EN.
module serial_subtractor8b (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       BIN,
    output logic [7:0] D,
    output logic       BOUT,
    output logic       BUSY,
    output logic       DONE,
    output logic       Z,
    output logic       N,
    output logic       V,
    output logic [1:0] DBG_STATE
);

    // Handshake: START is sampled on every rising edge but only acted on in IDLE or DONE;
    // DONE is a one-cycle pulse and D/BOUT/Z/N/V stay stable until the next pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_res;
    logic [2:0] r_cnt;
    logic       r_br;
    logic [7:0] r_d;
    logic       r_bout;
    logic       r_busy;
    logic       r_done;

    logic       w_a_bit;
    logic       w_b_bit;
    logic       w_d_bit;
    logic       w_br_next;
    logic [7:0] w_res_next;

    assign w_a_bit    = r_a[r_cnt];
    assign w_b_bit    = r_b[r_cnt];
    assign w_d_bit    = w_a_bit ^ w_b_bit ^ r_br;
    assign w_br_next  = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);
    // Result bits enter at the MSB so that after eight shifts bit 0 sits at r_res[0].
    assign w_res_next = {w_d_bit, r_res[7:1]};

`ifdef SERIAL_SUB_FLAGS_EN
    logic r_z;
    logic r_n;
    logic r_v;
    assign Z = r_z;
    assign N = r_n;
    assign V = r_v;
`else
    assign Z = 1'b0;
    assign N = 1'b0;
    assign V = 1'b0;
`endif

    assign D         = r_d;
    assign BOUT      = r_bout;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign DBG_STATE = r_state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_res   <= 8'h00;
            r_cnt   <= 3'd0;
            r_br    <= 1'b0;
            r_d     <= 8'h00;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_br    <= BIN;
                        r_cnt   <= 3'd0;
                        r_res   <= 8'h00;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_res <= w_res_next;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_d     <= w_res_next;
                        r_bout  <= w_br_next;
`ifdef SERIAL_SUB_FLAGS_EN
                        r_z     <= (w_res_next == 8'h00);
                        r_n     <= w_res_next[7];
                        r_v     <= (r_a[7] != r_b[7]) && (w_res_next[7] != r_a[7]);
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor8b.sv
// Directed bench for serial_subtractor8b: hand-computed vectors, latency, back-to-back, ignored START and reset abort.
// Flag expectations follow SERIAL_SUB_FLAGS_EN (flags expected 0 when it is undefined).
module tb_serial_subtractor8b;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [7:0] A;
    logic [7:0] B;
    logic       BIN;
    logic [7:0] D;
    logic       BOUT;
    logic       BUSY;
    logic       DONE;
    logic       Z;
    logic       N;
    logic       V;
    logic [1:0] DBG_STATE;

    int n_checks = 0;
    int n_err    = 0;
    int lat;
    int busy_cnt;
    int pulses;

`ifdef SERIAL_SUB_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    serial_subtractor8b dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .BIN(BIN),
        .D(D), .BOUT(BOUT), .BUSY(BUSY), .DONE(DONE), .Z(Z), .N(N), .V(V),
        .DBG_STATE(DBG_STATE)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; START is sampled on the following rising edge (edge 0).
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bin);
        START = 1'b1;
        A     = a;
        B     = b;
        BIN   = bin;
        @(negedge CLK);
        START = 1'b0;
        A     = 8'($urandom_range(0, 255));
        B     = 8'($urandom_range(0, 255));
        BIN   = 1'($urandom_range(0, 1));
    endtask

    // Bounded wait for DONE; lat counts falling edges since the one after edge 0.
    task automatic wait_done();
        lat      = 1;
        busy_cnt = 0;
        while (!DONE && lat < 20) begin
            if (BUSY) busy_cnt++;
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input logic [7:0] ed, input logic eb,
                             input logic ez, input logic en, input logic ev);
        chk({tag, "_done"}, DONE, 1'b1);
        chk({tag, "_d"}, D, ed);
        chk({tag, "_bout"}, BOUT, eb);
        chk({tag, "_z"}, Z, ez & FL);
        chk({tag, "_n"}, N, en & FL);
        chk({tag, "_v"}, V, ev & FL);
    endtask

    task automatic count_pulses(input int cycles);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (DONE) pulses++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                           input logic [7:0] ed, input logic eb, input logic ez, input logic en,
                           input logic ev);
        issue(a, b, bin);
        wait_done();
        chk({tag, "_lat"}, lat, 9);
        check_res(tag, ed, eb, ez, en, ev);
        @(negedge CLK);
        chk({tag, "_pulse1"}, DONE, 1'b0);
        chk({tag, "_hold"}, D, ed);
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        BIN   = 1'b0;
        #12;
        chk("rst_d", D, 8'h00);
        chk("rst_bout", BOUT, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_zn_v", {Z, N, V}, 3'b000);
        chk("rst_state", DBG_STATE, 2'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Basic vector with BUSY width and DONE latency
        issue(8'h05, 8'h03, 1'b0);
        wait_done();
        chk("v1_lat", lat, 9);
        chk("v1_busy_cycles", busy_cnt, 8);
        chk("v1_busy_at_done", BUSY, 1'b0);
        check_res("v1", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("v1_idle", DBG_STATE, 2'd0);

        run_vec("v2", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vec("v3", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
        run_vec("v_7f_80", 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
        run_vec("v_7f_ff_1", 8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec("v_00_ff_1", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

        // Back-to-back: START held in DONE starts the next operation
        issue(8'h10, 8'h0F, 1'b1);
        wait_done();
        check_res("b2b1", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(8'h01, 8'h02, 1'b0);
        chk("b2b_busy", BUSY, 1'b1);
        chk("b2b_hold_d", D, 8'h00);
        chk("b2b_hold_z", Z, FL);
        wait_done();
        chk("b2b2_lat", lat, 9);
        check_res("b2b2", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);

        // START during RUN is ignored
        issue(8'h20, 8'h10, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        issue(8'hFF, 8'h00, 1'b0);
        lat = 0;
        wait_done();
        chk("ign_lat", lat, 6);
        check_res("ign", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        count_pulses(14);
        chk("ign_no_second", pulses, 0);
        chk("ign_hold_d", D, 8'h10);

        // Reset during RUN aborts without a DONE pulse
        issue(8'h33, 8'h11, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("ar_d", D, 8'h00);
        chk("ar_busy", BUSY, 1'b0);
        chk("ar_done", DONE, 1'b0);
        chk("ar_state", DBG_STATE, 2'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        count_pulses(12);
        chk("ar_no_done", pulses, 0);
        chk("ar_d_held0", D, 8'h00);
        run_vec("after_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
